// File: rtl/script_sequencer_if.sv
// Command handshake between the script sequencer and the UART protocol block.
// One (op, dev) command is offered at a time; it transfers when op_valid & op_ready.
interface script_sequencer_if;
  logic       op_valid;
  logic       op_ready;
  logic [4:0] op;
  logic [4:0] dev;

  modport master (output op_valid, output op, output dev, input op_ready);
  modport slave  (input op_valid, input op, input dev, output op_ready);
endinterface

// File: rtl/script_sequencer.sv
// Executes a kitchen script from a synchronous ROM: issues commands, delays,
// polls game feedback with timeout, jumps and ends.
//
//  state | meaning
//  IDLE  | stopped, waiting for a run rising edge
//  FETCH | pc presented, waiting one cycle for ROM data
//  EXEC  | decode current script word
//  ISSUE | command offered on op/dev until accepted
//  DELAY | counting down N ticks
//  POLL  | waiting for a signal bit, bounded by the timeout
//  DONE  | script reached END
//  ERROR | illegal instruction or poll timeout
module script_sequencer #(
  parameter int PC_W          = 8,
  parameter int TICK_CYCLES   = 100000,
  parameter int TIMEOUT_TICKS = 255
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            run,
  input  logic            stop,
  output logic [PC_W-1:0] pc,
  input  logic [15:0]     script,
  input  logic [3:0]      signal,
  output logic            busy,
  output logic            done,
  output logic            err,
  script_sequencer_if.master cmd
);

  localparam int TC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int TL_W = ($clog2(TIMEOUT_TICKS) > 8) ? $clog2(TIMEOUT_TICKS) : 8;
  localparam logic [TC_W-1:0] TICK_LAST = TC_W'(TICK_CYCLES - 1);
  localparam logic [TL_W-1:0] TO_LAST   = TL_W'(TIMEOUT_TICKS - 1);

  localparam logic [2:0] CLS_ACT = 3'd0;
  localparam logic [2:0] CLS_JMP = 3'd1;
  localparam logic [2:0] CLS_DLY = 3'd2;
  localparam logic [2:0] CLS_WTU = 3'd3;
  localparam logic [2:0] CLS_END = 3'd4;

  typedef enum logic [2:0] {
    IDLE, FETCH, EXEC, ISSUE, DELAY, POLL, DONE, ERROR
  } state_t;

  state_t          state;
  logic            run_q;
  logic [TC_W-1:0] tick_cnt;
  logic [TL_W-1:0] tick_left;

  logic [2:0]      cls;
  logic            sel_bit;
  logic            jmp_take;
  logic [PC_W-1:0] pc_inc;
  logic [7:0]      dly_n;
  logic            run_rise;
  logic            tick_end;

  always_comb begin
    cls      = script[15:13];
    sel_bit  = signal[script[9:8]];
    jmp_take = script[12] | (sel_bit == script[10]);
    pc_inc   = pc + PC_W'(1);
    dly_n    = script[7:0];
    run_rise = run & ~run_q;
    tick_end = (tick_cnt == '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      run_q        <= 1'b0;
      pc           <= '0;
      tick_cnt     <= '0;
      tick_left    <= '0;
      cmd.op_valid <= 1'b0;
      cmd.op       <= '0;
      cmd.dev      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      run_q <= run;
      // stop overrides everything, even a handshake landing this cycle
      if (stop) begin
        state        <= IDLE;
        pc           <= '0;
        tick_cnt     <= '0;
        tick_left    <= '0;
        cmd.op_valid <= 1'b0;
        busy         <= 1'b0;
        done         <= 1'b0;
        err          <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE, ERROR: begin
            if (run_rise) begin
              state <= FETCH;
              pc    <= '0;
              busy  <= 1'b1;
              done  <= 1'b0;
              err   <= 1'b0;
            end
          end
          FETCH: state <= EXEC;
          EXEC: begin
            case (cls)
              CLS_ACT: begin
                state        <= ISSUE;
                cmd.op       <= script[4:0];
                cmd.dev      <= script[12:8];
                cmd.op_valid <= 1'b1;
              end
              CLS_JMP: begin
                pc    <= jmp_take ? script[PC_W-1:0] : pc_inc;
                state <= FETCH;
              end
              CLS_DLY: begin
                if (dly_n == 8'd0) begin
                  pc    <= pc_inc;
                  state <= FETCH;
                end else begin
                  state     <= DELAY;
                  tick_cnt  <= TICK_LAST;
                  tick_left <= TL_W'(dly_n - 8'd1);
                end
              end
              CLS_WTU: begin
                state     <= POLL;
                tick_cnt  <= TICK_LAST;
                tick_left <= TO_LAST;
              end
              CLS_END: begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
              default: begin
                state <= ERROR;
                busy  <= 1'b0;
                err   <= 1'b1;
              end
            endcase
          end
          ISSUE: begin
            if (cmd.op_ready) begin
              cmd.op_valid <= 1'b0;
              pc           <= pc_inc;
              state        <= FETCH;
            end
          end
          DELAY: begin
            if (!tick_end) begin
              tick_cnt <= tick_cnt - 1'b1;
            end else if (tick_left == '0) begin
              pc    <= pc_inc;
              state <= FETCH;
            end else begin
              tick_left <= tick_left - 1'b1;
              tick_cnt  <= TICK_LAST;
            end
          end
          POLL: begin
            if (sel_bit) begin
              pc    <= pc_inc;
              state <= FETCH;
            end else if (!tick_end) begin
              tick_cnt <= tick_cnt - 1'b1;
            end else if (tick_left == '0) begin
              state <= ERROR;
              busy  <= 1'b0;
              err   <= 1'b1;
            end else begin
              tick_left <= tick_left - 1'b1;
              tick_cnt  <= TICK_LAST;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
